// File: rtl/ppu_lcd_timing_scaler_if.sv
// Frame-buffer read port and page-swap handshake between the LCD scaler and the PPU side.
interface ppu_lcd_timing_scaler_if #(
  parameter int SRC_AW = 8
);
  logic [2*SRC_AW:0] vbuf_addr;
  logic [23:0]       vbuf_rgb;
  logic              swap_req;
  logic              swap_ack;

  modport master (output vbuf_addr, input vbuf_rgb, input swap_req, output swap_ack);
  modport slave  (input vbuf_addr, output vbuf_rgb, output swap_req, input swap_ack);
endinterface

// File: rtl/ppu_lcd_timing_scaler.sv
// LCD raster generator and integer-scale frame-buffer reader with X/Y mirroring and a
// handshaked double-buffer page swap; drives registered RGB, DE and syncs to the panel.
module ppu_lcd_timing_scaler #(
  parameter int          H_TOTAL     = 1056,
  parameter int          V_TOTAL     = 525,
  parameter int          HS_W        = 30,
  parameter int          VS_W        = 13,
  parameter int          H_BP        = 46,
  parameter int          V_BP        = 23,
  parameter int          H_ACT       = 800,
  parameter int          V_ACT       = 480,
  parameter int          SCALE_SHIFT = 1,
  parameter int          SRC_AW      = 8,
  parameter int          GAME_W      = 256,
  parameter int          GAME_H      = 240,
  parameter int          RD_LAT      = 1,
  parameter logic [23:0] BORDER_RGB  = 24'h0,
  parameter bit          INIT_PAGE   = 1'b1
) (
  input  logic                           i_lcd_clk,
  input  logic                           i_lcd_rst,
  ppu_lcd_timing_scaler_if.master        vbuf,
  input  logic                           i_flip_x,
  input  logic                           i_flip_y,
  output logic [7:0]                     o_lcd_r,
  output logic [7:0]                     o_lcd_g,
  output logic [7:0]                     o_lcd_b,
  output logic                           o_lcd_de,
  output logic                           o_lcd_hsd,
  output logic                           o_lcd_vsd,
  output logic                           o_vblank,
  output logic                           o_frame_start
);
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  // control word layout: {de, game, hsd, vsd}
  localparam logic [3:0] CTL_RST = 4'b0011;

  logic [XW-1:0]     xcnt;
  logic [YW-1:0]     line;
  logic              fe;
  logic              page, pending, flip_x_q, flip_y_q;
  int                sx, sy, sx_m, sy_m, src_x_full, src_y_full;
  logic              h_act, v_act, game, hsd_n, vsd_n;
  logic [SRC_AW-1:0] src_x, src_y;
  logic [3:0]        ctl_s1;
  logic [3:0]        ctl_d [RD_LAT];
  logic [3:0]        ctl_o;
  logic [23:0]       rgb_q;

  assign fe = (xcnt == XW'(H_TOTAL - 1)) && (line == YW'(V_TOTAL - 1));

  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      xcnt <= '0;
      line <= '0;
    end else if (xcnt == XW'(H_TOTAL - 1)) begin
      xcnt <= '0;
      line <= (line == YW'(V_TOTAL - 1)) ? '0 : line + YW'(1);
    end else begin
      xcnt <= xcnt + XW'(1);
    end
  end

  always_comb begin
    sx         = int'(xcnt) - H_BP;
    sy         = int'(line) - V_BP;
    h_act      = (sx >= 0) && (sx < H_ACT);
    v_act      = (sy >= 0) && (sy < V_ACT);
    sx_m       = flip_x_q ? (H_ACT - 1 - sx) : sx;
    sy_m       = flip_y_q ? (V_ACT - 1 - sy) : sy;
    src_x_full = sx_m >>> SCALE_SHIFT;
    src_y_full = sy_m >>> SCALE_SHIFT;
    // game window test uses the unclipped source coordinate, before address truncation
    game       = h_act && v_act && (src_x_full < GAME_W) && (src_y_full < GAME_H);
    src_x      = src_x_full[SRC_AW-1:0];
    src_y      = src_y_full[SRC_AW-1:0];
    hsd_n      = int'(xcnt) >= HS_W;
    vsd_n      = int'(line) >= VS_W;
  end

  assign o_vblank      = !v_act;
  assign o_frame_start = !i_lcd_rst && (xcnt == '0) && (line == '0);

  // A request on the frame-end cycle itself still counts for that frame end.
  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      page          <= INIT_PAGE;
      pending       <= 1'b0;
      vbuf.swap_ack <= 1'b0;
      flip_x_q      <= 1'b0;
      flip_y_q      <= 1'b0;
    end else begin
      vbuf.swap_ack <= 1'b0;
      if (fe) begin
        flip_x_q <= i_flip_x;
        flip_y_q <= i_flip_y;
        if (pending || vbuf.swap_req) begin
          page          <= ~page;
          pending       <= 1'b0;
          vbuf.swap_ack <= 1'b1;
        end
      end else if (vbuf.swap_req) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      vbuf.vbuf_addr <= '0;
      ctl_s1         <= CTL_RST;
      for (int i = 0; i < RD_LAT; i++) ctl_d[i] <= CTL_RST;
    end else begin
      vbuf.vbuf_addr <= {page, src_y, src_x};
      ctl_s1         <= {h_act && v_act, game, hsd_n, vsd_n};
      ctl_d[0]       <= ctl_s1;
      for (int i = 1; i < RD_LAT; i++) ctl_d[i] <= ctl_d[i-1];
    end
  end

  assign ctl_o = ctl_d[RD_LAT-1];

  always_ff @(posedge i_lcd_clk) begin
    if (i_lcd_rst) begin
      rgb_q     <= '0;
      o_lcd_de  <= 1'b0;
      o_lcd_hsd <= 1'b1;
      o_lcd_vsd <= 1'b1;
    end else begin
      rgb_q     <= ctl_o[3] ? (ctl_o[2] ? vbuf.vbuf_rgb : BORDER_RGB) : 24'h0;
      o_lcd_de  <= ctl_o[3];
      o_lcd_hsd <= ctl_o[1];
      o_lcd_vsd <= ctl_o[0];
    end
  end

  assign {o_lcd_r, o_lcd_g, o_lcd_b} = rgb_q;
endmodule

// File: tb/tb_ppu_lcd_timing_scaler.sv
// Directed bench: small 40x20 raster (800 clocks/frame), one instance with default scale and
// latency, one with SCALE_SHIFT=0 / RD_LAT=3. Time t counts clocks since reset release.
module tb_ppu_lcd_timing_scaler;
  localparam logic [23:0] BRD = 24'hA55A3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ppu_lcd_timing_scaler_if #(.SRC_AW(4)) ifa ();
  ppu_lcd_timing_scaler_if #(.SRC_AW(4)) ifb ();

  logic       flip_x, flip_y;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       de_a, hsd_a, vsd_a, vbl_a, fs_a;
  logic       de_b, hsd_b, vsd_b, vbl_b, fs_b;
  logic [23:0] b1, b2;
  int t;
  int n_pass = 0;
  int n_total = 0;

  ppu_lcd_timing_scaler #(
    .H_TOTAL(40), .V_TOTAL(20), .HS_W(4), .VS_W(2), .H_BP(6), .V_BP(3), .H_ACT(24), .V_ACT(12),
    .SCALE_SHIFT(1), .SRC_AW(4), .GAME_W(8), .GAME_H(5), .RD_LAT(1), .BORDER_RGB(BRD), .INIT_PAGE(1'b1)
  ) dut_a (
    .i_lcd_clk(clk), .i_lcd_rst(rst), .vbuf(ifa.master), .i_flip_x(flip_x), .i_flip_y(flip_y),
    .o_lcd_r(r_a), .o_lcd_g(g_a), .o_lcd_b(b_a), .o_lcd_de(de_a), .o_lcd_hsd(hsd_a),
    .o_lcd_vsd(vsd_a), .o_vblank(vbl_a), .o_frame_start(fs_a)
  );

  ppu_lcd_timing_scaler #(
    .H_TOTAL(40), .V_TOTAL(20), .HS_W(4), .VS_W(2), .H_BP(6), .V_BP(3), .H_ACT(24), .V_ACT(12),
    .SCALE_SHIFT(0), .SRC_AW(4), .GAME_W(8), .GAME_H(5), .RD_LAT(3), .BORDER_RGB(BRD), .INIT_PAGE(1'b1)
  ) dut_b (
    .i_lcd_clk(clk), .i_lcd_rst(rst), .vbuf(ifb.master), .i_flip_x(1'b0), .i_flip_y(1'b0),
    .o_lcd_r(r_b), .o_lcd_g(g_b), .o_lcd_b(b_b), .o_lcd_de(de_b), .o_lcd_hsd(hsd_b),
    .o_lcd_vsd(vsd_b), .o_vblank(vbl_b), .o_frame_start(fs_b)
  );

  function automatic logic [23:0] vb(input logic [8:0] a);
    return {a, 15'h5A3};
  endfunction

  // frame-buffer models: 1-cycle and 3-cycle read latency
  always @(posedge clk) ifa.vbuf_rgb <= vb(ifa.vbuf_addr);
  always @(posedge clk) begin
    b1 <= vb(ifb.vbuf_addr);
    b2 <= b1;
    ifb.vbuf_rgb <= b2;
  end

  always @(posedge clk) if (rst) t <= 0; else t <= t + 1;

  task automatic wait_t(input int target);
    int n = 0;
    while (t < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (t != target) begin
      n_total++;
      $display("FAIL wait_t: t=%0d wanted %0d", t, target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++; if ({r_a, g_a, b_a} !== 24'h0) $display("FAIL rst_rgb: got %h exp 0", {r_a, g_a, b_a}); else n_pass++;
    n_total++; if (de_a !== 1'b0) $display("FAIL rst_de: got %b exp 0", de_a); else n_pass++;
    n_total++; if ({hsd_a, vsd_a} !== 2'b11) $display("FAIL rst_sync: got %b exp 11", {hsd_a, vsd_a}); else n_pass++;
    n_total++; if (ifa.swap_ack !== 1'b0) $display("FAIL rst_ack: got %b exp 0", ifa.swap_ack); else n_pass++;
    n_total++; if (ifa.vbuf_addr !== 9'h0) $display("FAIL rst_addr: got %h exp 0", ifa.vbuf_addr); else n_pass++;
    n_total++; if (fs_a !== 1'b0) $display("FAIL rst_fs: got %b exp 0", fs_a); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (fs_a !== 1'b1) $display("FAIL fs_t0: got %b exp 1", fs_a); else n_pass++;
    n_total++; if (vbl_a !== 1'b1) $display("FAIL vbl_t0: got %b exp 1", vbl_a); else n_pass++;
  endtask

  task automatic test_timing();
    wait_t(2);   n_total++; if (vsd_a !== 1'b1) $display("FAIL vsd_t2: got %b exp 1", vsd_a); else n_pass++;
    wait_t(3);   n_total++; if (vsd_a !== 1'b0) $display("FAIL vsd_t3: got %b exp 0", vsd_a); else n_pass++;
    wait_t(82);  n_total++; if (vsd_a !== 1'b0) $display("FAIL vsd_t82: got %b exp 0", vsd_a); else n_pass++;
    wait_t(83);  n_total++; if (vsd_a !== 1'b1) $display("FAIL vsd_t83: got %b exp 1", vsd_a); else n_pass++;
    wait_t(120); n_total++; if (vbl_a !== 1'b0) $display("FAIL vbl_t120: got %b exp 0", vbl_a); else n_pass++;
    wait_t(128); n_total++; if (de_a !== 1'b0) $display("FAIL de_t128: got %b exp 0", de_a); else n_pass++;
    wait_t(129); n_total++; if (de_a !== 1'b1) $display("FAIL de_t129: got %b exp 1", de_a); else n_pass++;
    wait_t(203); n_total++; if (hsd_a !== 1'b0) $display("FAIL hsd_t203: got %b exp 0", hsd_a); else n_pass++;
    wait_t(206); n_total++; if (hsd_a !== 1'b0) $display("FAIL hsd_t206: got %b exp 0", hsd_a); else n_pass++;
    wait_t(207); n_total++; if (hsd_a !== 1'b1) $display("FAIL hsd_t207: got %b exp 1", hsd_a); else n_pass++;
  endtask

  task automatic test_addr();
    wait_t(245); n_total++; if ({de_a, r_a, g_a, b_a} !== 25'h0) $display("FAIL inactive: got %h exp 0", {de_a, r_a, g_a, b_a}); else n_pass++;
    wait_t(252); n_total++; if (ifa.vbuf_addr !== 9'h112) $display("FAIL addr_5_3: got %h exp 112", ifa.vbuf_addr); else n_pass++;
    wait_t(254); n_total++; if ({r_a, g_a, b_a} !== vb(9'h112)) $display("FAIL rgb_5_3: got %h exp %h", {r_a, g_a, b_a}, vb(9'h112)); else n_pass++;
    n_total++; if (de_a !== 1'b1) $display("FAIL de_5_3: got %b exp 1", de_a); else n_pass++;
    wait_t(264); n_total++; if ({r_a, g_a, b_a} !== vb(9'h117)) $display("FAIL rgb_lastx: got %h exp %h", {r_a, g_a, b_a}, vb(9'h117)); else n_pass++;
    wait_t(265); n_total++; if ({r_a, g_a, b_a} !== BRD) $display("FAIL border_x: got %h exp %h", {r_a, g_a, b_a}, BRD); else n_pass++;
    wait_t(534); n_total++; if ({r_a, g_a, b_a} !== BRD) $display("FAIL border_y: got %h exp %h", {r_a, g_a, b_a}, BRD); else n_pass++;
  endtask

  task automatic test_frame();
    wait_t(599); n_total++; if (vbl_a !== 1'b0) $display("FAIL vbl_t599: got %b exp 0", vbl_a); else n_pass++;
    wait_t(600); n_total++; if (vbl_a !== 1'b1) $display("FAIL vbl_t600: got %b exp 1", vbl_a); else n_pass++;
    wait_t(799); n_total++; if (fs_a !== 1'b0) $display("FAIL fs_t799: got %b exp 0", fs_a); else n_pass++;
    wait_t(800); n_total++; if (fs_a !== 1'b1) $display("FAIL fs_t800: got %b exp 1", fs_a); else n_pass++;
    wait_t(801); n_total++; if (fs_a !== 1'b0) $display("FAIL fs_t801: got %b exp 0", fs_a); else n_pass++;
  endtask

  task automatic test_flip();
    wait_t(1052); n_total++; if (ifa.vbuf_addr !== 9'h112) $display("FAIL noflip_f1: got %h exp 112", ifa.vbuf_addr); else n_pass++;
    wait_t(1100); flip_x = 1'b1;
    wait_t(1849); n_total++; if ({r_a, g_a, b_a} !== BRD) $display("FAIL flipx_sx0: got %h exp %h", {r_a, g_a, b_a}, BRD); else n_pass++;
    wait_t(1855); n_total++; if (ifa.vbuf_addr !== 9'h117) $display("FAIL flipx_addr: got %h exp 117", ifa.vbuf_addr); else n_pass++;
    wait_t(1857); n_total++; if ({r_a, g_a, b_a} !== vb(9'h117)) $display("FAIL flipx_rgb: got %h exp %h", {r_a, g_a, b_a}, vb(9'h117)); else n_pass++;
    wait_t(2000); flip_x = 1'b0; flip_y = 1'b1;
    wait_t(2095); n_total++; if (ifa.vbuf_addr !== 9'h147) $display("FAIL flip_midframe: got %h exp 147", ifa.vbuf_addr); else n_pass++;
    wait_t(2534); n_total++; if ({r_a, g_a, b_a} !== BRD) $display("FAIL flipy_border: got %h exp %h", {r_a, g_a, b_a}, BRD); else n_pass++;
    wait_t(2652); n_total++; if (ifa.vbuf_addr !== 9'h142) $display("FAIL flipy_addr: got %h exp 142", ifa.vbuf_addr); else n_pass++;
    wait_t(2700); flip_y = 1'b0;
  endtask

  task automatic test_swap();
    wait_t(3300); ifa.swap_req = 1'b1; @(negedge clk); ifa.swap_req = 1'b0;
    wait_t(3999); n_total++; if (ifa.swap_ack !== 1'b0) $display("FAIL ack_t3999: got %b exp 0", ifa.swap_ack); else n_pass++;
    wait_t(4000); n_total++; if (ifa.swap_ack !== 1'b1) $display("FAIL ack_t4000: got %b exp 1", ifa.swap_ack); else n_pass++;
    wait_t(4001); n_total++; if (ifa.swap_ack !== 1'b0) $display("FAIL ack_t4001: got %b exp 0", ifa.swap_ack); else n_pass++;
    wait_t(4252); n_total++; if (ifa.vbuf_addr !== 9'h012) $display("FAIL page_f5: got %h exp 012", ifa.vbuf_addr); else n_pass++;
  endtask

  task automatic test_no_swap();
    wait_t(4800); n_total++; if (ifa.swap_ack !== 1'b0) $display("FAIL noreq_ack1: got %b exp 0", ifa.swap_ack); else n_pass++;
    wait_t(5052); n_total++; if (ifa.vbuf_addr !== 9'h012) $display("FAIL noreq_page: got %h exp 012", ifa.vbuf_addr); else n_pass++;
    wait_t(5600); n_total++; if (ifa.swap_ack !== 1'b0) $display("FAIL noreq_ack2: got %b exp 0", ifa.swap_ack); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      wait_t(5700 + 100 * k); ifa.swap_req = 1'b1; @(negedge clk); ifa.swap_req = 1'b0;
    end
    wait_t(6400); n_total++; if (ifa.swap_ack !== 1'b1) $display("FAIL multi_ack: got %b exp 1", ifa.swap_ack); else n_pass++;
    wait_t(6401); n_total++; if (ifa.swap_ack !== 1'b0) $display("FAIL multi_ack_end: got %b exp 0", ifa.swap_ack); else n_pass++;
    wait_t(6652); n_total++; if (ifa.vbuf_addr !== 9'h112) $display("FAIL multi_page: got %h exp 112", ifa.vbuf_addr); else n_pass++;
    wait_t(7200); n_total++; if (ifa.swap_ack !== 1'b0) $display("FAIL multi_absorb: got %b exp 0", ifa.swap_ack); else n_pass++;
    wait_t(7999); ifa.swap_req = 1'b1; @(negedge clk); ifa.swap_req = 1'b0;
    n_total++; if (ifa.swap_ack !== 1'b1) $display("FAIL fe_req_ack: got %b exp 1", ifa.swap_ack); else n_pass++;
    wait_t(8252); n_total++; if (ifa.vbuf_addr !== 9'h012) $display("FAIL fe_req_page: got %h exp 012", ifa.vbuf_addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    wait_t(8630);
    rst = 1'b1;
    @(negedge clk);
    n_total++; if ({de_a, hsd_a, vsd_a} !== 3'b011) $display("FAIL mid_ctl: got %b exp 011", {de_a, hsd_a, vsd_a}); else n_pass++;
    n_total++; if ({r_a, g_a, b_a} !== 24'h0) $display("FAIL mid_rgb: got %h exp 0", {r_a, g_a, b_a}); else n_pass++;
    n_total++; if ({ifa.vbuf_addr, ifa.swap_ack, fs_a} !== 11'h0) $display("FAIL mid_misc: got %h exp 0", {ifa.vbuf_addr, ifa.swap_ack, fs_a}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (fs_a !== 1'b1) $display("FAIL mid_restart_fs: got %b exp 1", fs_a); else n_pass++;
  endtask

  task automatic test_param_sweep();
    wait_t(4);   n_total++; if (vsd_b !== 1'b1) $display("FAIL b_vsd_t4: got %b exp 1", vsd_b); else n_pass++;
    wait_t(5);   n_total++; if (vsd_b !== 1'b0) $display("FAIL b_vsd_t5: got %b exp 0", vsd_b); else n_pass++;
    wait_t(130); n_total++; if (de_b !== 1'b0) $display("FAIL b_de_t130: got %b exp 0", de_b); else n_pass++;
    wait_t(131); n_total++; if (de_b !== 1'b1) $display("FAIL b_de_t131: got %b exp 1", de_b); else n_pass++;
    wait_t(252);
    n_total++; if (ifb.vbuf_addr !== 9'h135) $display("FAIL b_addr: got %h exp 135", ifb.vbuf_addr); else n_pass++;
    n_total++; if (ifa.vbuf_addr !== 9'h112) $display("FAIL a_page_after_rst: got %h exp 112", ifa.vbuf_addr); else n_pass++;
    wait_t(256); n_total++; if ({r_b, g_b, b_b} !== vb(9'h135)) $display("FAIL b_rgb: got %h exp %h", {r_b, g_b, b_b}, vb(9'h135)); else n_pass++;
    wait_t(259); n_total++; if ({r_b, g_b, b_b} !== BRD) $display("FAIL b_border: got %h exp %h", {r_b, g_b, b_b}, BRD); else n_pass++;
    wait_t(799); n_total++; if ({fs_b, vbl_b, hsd_b} !== 3'b011) $display("FAIL b_fe: got %b exp 011", {fs_b, vbl_b, hsd_b}); else n_pass++;
    wait_t(800); n_total++; if (fs_b !== 1'b1) $display("FAIL b_fs_wrap: got %b exp 1", fs_b); else n_pass++;
  endtask

  initial begin
    flip_x = 1'b0;
    flip_y = 1'b0;
    ifa.swap_req = 1'b0;
    ifb.swap_req = 1'b0;
    test_reset();
    test_timing();
    test_addr();
    test_frame();
    test_flip();
    test_swap();
    test_no_swap();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
